// File: rtl/spi_pkg.sv
// spi_pkg: command codes, status/control bit positions, FSM states and shared types for the contactor engine
package spi_pkg;
    parameter int SPI_WORD_LEN = 8;
    typedef enum logic [7:0] {
        CMD_READ_CONTACTOR    = 8'h01,
        CMD_READ_FEEDBACK     = 8'h02,
        CMD_READ_STATUS       = 8'h03,
        CMD_READ_SHUTDOWN     = 8'h04,
        CMD_WRITE_CONTACTOR   = 8'h81,
        CMD_WRITE_CONTROL     = 8'h82,
        CMD_WRITE_SHUTDOWN    = 8'h83,
        CMD_WRITE_PG_SHUTDOWN = 8'h84
    } spi_cmd_t;
    // status bits are counted down from the MSB so they track WORD_LEN
    localparam int STATUS_TIMEOUT_OFS = 0;
    localparam int STATUS_INVALID_OFS = 1;
    localparam int CTRL_RESET_BIT     = 0;
    localparam int CTRL_CLEAR_BIT     = 1;
    typedef struct packed {
        logic plus;
        logic minus;
    } contactor_data_t;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_IDX, ST_DATA, ST_DONE} state_t;
    function automatic logic cmd_known(input logic [7:0] c);
        return c inside {CMD_READ_CONTACTOR, CMD_READ_FEEDBACK, CMD_READ_STATUS, CMD_READ_SHUTDOWN,
                         CMD_WRITE_CONTACTOR, CMD_WRITE_CONTROL, CMD_WRITE_SHUTDOWN, CMD_WRITE_PG_SHUTDOWN};
    endfunction
    function automatic logic cmd_uses_idx(input logic [7:0] c);
        return c inside {CMD_READ_CONTACTOR, CMD_READ_FEEDBACK, CMD_WRITE_CONTACTOR};
    endfunction
endpackage

// File: rtl/spi_contactor_ctrl_if.sv
// spi_contactor_ctrl_if: word-level link between the SPI shifter (master) and the command engine (slave)
interface spi_contactor_ctrl_if
    import spi_pkg::*;
#(
    parameter int WORD_LEN = SPI_WORD_LEN
);
    logic                frame_start;
    logic                frame_end;
    logic                rx_valid;
    logic [WORD_LEN-1:0] rx_data;
    logic [WORD_LEN-1:0] tx_data;
    modport master (output frame_start, frame_end, rx_valid, rx_data, input tx_data);
    modport slave (input frame_start, frame_end, rx_valid, rx_data, output tx_data);
endinterface

// File: rtl/fb_timeout_monitor.sv
// fb_timeout_monitor: per-channel feedback synchroniser, mismatch counter and sticky timeout flag
module fb_timeout_monitor
    import spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  contactor_data_t i_cmd,
    input  contactor_data_t i_fb,
    output contactor_data_t o_fb_sync,
    output logic            o_trip,
    output logic            o_flag
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    contactor_data_t r_s1, r_s2, r_cmd_prev;
    logic [CW-1:0]   r_cnt;
    logic            r_flag;
    assign o_fb_sync = r_s2;
    assign o_trip    = r_cnt == LIMIT;
    assign o_flag    = r_flag;
    // a fresh command restarts the window so the contactor gets its full settling time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_cmd_prev <= '0;
            r_cnt      <= '0;
            r_flag     <= 1'b0;
        end else begin
            r_s1       <= i_fb;
            r_s2       <= r_s1;
            r_cmd_prev <= i_cmd;
            r_cnt      <= (i_clr || i_cmd != r_cmd_prev || r_s2 == i_cmd) ? '0
                        : o_trip ? r_cnt : r_cnt + 1'b1;
            r_flag     <= o_trip | (r_flag & ~i_clr);
        end
    end
endmodule

// File: rtl/spi_contactor_ctrl.sv
// spi_contactor_ctrl: framed SPI command engine driving contactor command registers and shutdown latches
module spi_contactor_ctrl
    import spi_pkg::*;
#(
    parameter int WORD_LEN       = SPI_WORD_LEN,
    parameter int NUM_CH         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    spi_contactor_ctrl_if.slave spi,
    output logic [2*NUM_CH-1:0] contactor_cmd,
    input  logic [2*NUM_CH-1:0] feedback_in,
    output logic                shutdown_out,
    output logic                pg_shutdown_out,
    output logic                timeout_err,
    output logic                invalid_req
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [8:0] NCH = 9'(NUM_CH);
    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [IW-1:0]       r_idx;
    logic                r_cmd_ok, r_req_ok;
    logic [WORD_LEN-1:0] r_tx;
    logic [2*NUM_CH-1:0] r_regs;
    logic                r_shutdown, r_pg, r_invalid;
    logic [2*NUM_CH-1:0] w_fb_sync;
    logic [NUM_CH-1:0]   w_trip, w_flag;
    logic [IW-1:0]       w_idx;
    logic                w_hi, w_cmd_ok, w_idx_bad, w_req_ok;
    logic                w_commit, w_wr_con, w_rst_req, w_clr, w_wr_shd, w_wr_pg, w_inv_set;
    logic [WORD_LEN-1:0] w_rsp;
    assign contactor_cmd   = r_shutdown ? '0 : r_regs;
    assign shutdown_out    = r_shutdown;
    assign pg_shutdown_out = r_pg;
    assign timeout_err     = |w_flag;
    assign invalid_req     = r_invalid;
    assign spi.tx_data     = r_tx;
    assign w_idx     = spi.rx_data[IW-1:0];
    assign w_hi      = (spi.rx_data >> 8) != '0;
    assign w_cmd_ok  = !w_hi && cmd_known(spi.rx_data[7:0]);
    assign w_idx_bad = w_hi || {1'b0, spi.rx_data[7:0]} >= NCH;
    assign w_req_ok  = r_cmd_ok && !(cmd_uses_idx(r_cmd) && w_idx_bad);
    // a word coinciding with frame_start or frame_end never commits
    assign w_commit  = r_state == ST_DATA && spi.rx_valid && !spi.frame_start && !spi.frame_end && r_req_ok;
    assign w_wr_con  = w_commit && r_cmd == CMD_WRITE_CONTACTOR;
    assign w_rst_req = w_commit && r_cmd == CMD_WRITE_CONTROL && spi.rx_data[CTRL_RESET_BIT];
    assign w_clr     = w_commit && r_cmd == CMD_WRITE_CONTROL && spi.rx_data[CTRL_CLEAR_BIT];
    assign w_wr_shd  = w_commit && r_cmd == CMD_WRITE_SHUTDOWN;
    assign w_wr_pg   = w_commit && r_cmd == CMD_WRITE_PG_SHUTDOWN;
    assign w_inv_set = !spi.frame_start && (spi.frame_end
                     ? r_state inside {ST_CMD, ST_IDX, ST_DATA}
                     : spi.rx_valid && ((r_state == ST_CMD && !w_cmd_ok)
                       || (r_state == ST_IDX && r_cmd_ok && cmd_uses_idx(r_cmd) && w_idx_bad)));
    always_comb begin
        w_rsp = '0;
        w_rsp[1:0] = r_cmd == CMD_READ_CONTACTOR ? contactor_cmd[{w_idx, 1'b0} +: 2]
                   : r_cmd == CMD_READ_FEEDBACK  ? w_fb_sync[{w_idx, 1'b0} +: 2]
                   : r_cmd == CMD_READ_SHUTDOWN  ? {r_pg, r_shutdown} : 2'b00;
        w_rsp[WORD_LEN-1-STATUS_TIMEOUT_OFS] = r_cmd == CMD_READ_STATUS && timeout_err;
        w_rsp[WORD_LEN-1-STATUS_INVALID_OFS] = r_cmd == CMD_READ_STATUS && r_invalid;
        if (!w_req_ok) w_rsp = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_idx    <= '0;
            r_cmd_ok <= 1'b0;
            r_req_ok <= 1'b0;
            r_tx     <= '0;
        end else if (spi.frame_start) begin
            r_state <= ST_CMD;
            r_tx    <= '0;
        end else if (spi.frame_end) begin
            r_state <= ST_IDLE;
        end else if (spi.rx_valid) begin
            case (r_state)
                ST_CMD: begin
                    r_cmd    <= spi.rx_data[7:0];
                    r_cmd_ok <= w_cmd_ok;
                    r_state  <= ST_IDX;
                end
                ST_IDX: begin
                    r_idx    <= w_idx;
                    r_req_ok <= w_req_ok;
                    r_tx     <= w_rsp;
                    r_state  <= ST_DATA;
                end
                ST_DATA: r_state <= ST_DONE;
                default: r_state <= r_state;
            endcase
        end
    end
    // error sets are ORed in last so they win over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs     <= '0;
            r_shutdown <= 1'b0;
            r_pg       <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            if (w_rst_req) r_regs <= '0;
            else if (w_wr_con) r_regs[{r_idx, 1'b0} +: 2] <= spi.rx_data[1:0];
            r_shutdown <= (|w_trip) | (|w_flag) | (w_wr_shd ? spi.rx_data[0] : r_shutdown & ~w_rst_req);
            r_pg       <= w_wr_pg ? spi.rx_data[0] : r_pg;
            r_invalid  <= w_inv_set | (r_invalid & ~w_clr);
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fb_timeout_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mon (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (w_clr),
            .i_cmd    (contactor_cmd[2*i +: 2]),
            .i_fb     (feedback_in[2*i +: 2]),
            .o_fb_sync(w_fb_sync[2*i +: 2]),
            .o_trip   (w_trip[i]),
            .o_flag   (w_flag[i])
        );
    end
endmodule

// File: tb/tb_spi_contactor_ctrl.sv
// tb_spi_contactor_ctrl: directed frames against spi_contactor_ctrl with hand-computed expectations
module tb_spi_contactor_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] contactor_cmd, feedback_in;
    logic [15:0] fb_hold = '0;
    logic        shutdown_out, pg_shutdown_out, timeout_err, invalid_req;
    logic [7:0]  rsp;
    logic [15:0] cc;
    int          n_tests = 0;
    int          n_fail = 0;
    spi_contactor_ctrl_if #(.WORD_LEN(8)) spi ();
    spi_contactor_ctrl #(.WORD_LEN(8), .NUM_CH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi            (spi.slave),
        .contactor_cmd  (contactor_cmd),
        .feedback_in    (feedback_in),
        .shutdown_out   (shutdown_out),
        .pg_shutdown_out(pg_shutdown_out),
        .timeout_err    (timeout_err),
        .invalid_req    (invalid_req)
    );
    // contactors follow their commands except bits forced open by fb_hold
    assign feedback_in = contactor_cmd & ~fb_hold;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic word(input logic [7:0] w);
        spi.rx_valid = 1'b1;
        spi.rx_data  = w;
        @(negedge clk);
        spi.rx_valid = 1'b0;
        spi.rx_data  = '0;
    endtask
    task automatic frame(input logic [7:0] c, input logic [7:0] i, input logic [7:0] d,
                         output logic [7:0] r, output logic [15:0] cmd_after);
        spi.frame_start = 1'b1;
        @(negedge clk);
        spi.frame_start = 1'b0;
        word(c);
        word(i);
        r = spi.tx_data;
        word(d);
        cmd_after = contactor_cmd;
        spi.frame_end = 1'b1;
        @(negedge clk);
        spi.frame_end = 1'b0;
    endtask
    initial begin
        spi.frame_start = 1'b0;
        spi.frame_end   = 1'b0;
        spi.rx_valid    = 1'b0;
        spi.rx_data     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_cmd", contactor_cmd, 16'h0000);
        chk("reset_tx", 16'(spi.tx_data), 16'h0000);
        chk("reset_sd", 16'(shutdown_out), 16'h0000);
        chk("reset_pg", 16'(pg_shutdown_out), 16'h0000);
        chk("reset_tmo", 16'(timeout_err), 16'h0000);
        chk("reset_inv", 16'(invalid_req), 16'h0000);
        frame(8'h81, 8'h03, 8'h02, rsp, cc);
        chk("write_ch3", cc, 16'h0080);
        frame(8'h01, 8'h03, 8'h00, rsp, cc);
        chk("read_ch3", 16'(rsp), 16'h0002);
        frame(8'h81, 8'h09, 8'h03, rsp, cc);
        chk("bad_idx_no_write", cc, 16'h0080);
        chk("bad_idx_inv", 16'(invalid_req), 16'h0001);
        frame(8'h03, 8'h00, 8'h00, rsp, cc);
        chk("status_inv", 16'(rsp), 16'h0040);
        frame(8'h02, 8'h03, 8'h00, rsp, cc);
        chk("read_fb_ch3", 16'(rsp), 16'h0002);
        fb_hold = 16'h0003;
        frame(8'h81, 8'h00, 8'h03, rsp, cc);
        chk("write_ch0", cc, 16'h0083);
        repeat (16) @(negedge clk);
        chk("tmo_cycle18", 16'(timeout_err), 16'h0000);
        @(negedge clk);
        chk("tmo_cycle19", 16'(timeout_err), 16'h0001);
        chk("sd_cycle19", 16'(shutdown_out), 16'h0001);
        chk("cmd_forced_off", contactor_cmd, 16'h0000);
        frame(8'h03, 8'h00, 8'h00, rsp, cc);
        chk("status_both", 16'(rsp), 16'h00C0);
        frame(8'h82, 8'h00, 8'h02, rsp, cc);
        chk("clear_tmo", 16'(timeout_err), 16'h0000);
        chk("clear_inv", 16'(invalid_req), 16'h0000);
        chk("sd_kept", 16'(shutdown_out), 16'h0001);
        fb_hold = '0;
        frame(8'h83, 8'h00, 8'h00, rsp, cc);
        chk("restore", cc, 16'h0083);
        spi.frame_start = 1'b1;
        @(negedge clk);
        spi.frame_start = 1'b0;
        word(8'h81);
        word(8'h01);
        spi.frame_end = 1'b1;
        @(negedge clk);
        spi.frame_end = 1'b0;
        chk("abort_inv", 16'(invalid_req), 16'h0001);
        chk("abort_no_write", contactor_cmd, 16'h0083);
        frame(8'h81, 8'h01, 8'h01, rsp, cc);
        chk("write_ch1", cc, 16'h0087);
        frame(8'h81, 8'h07, 8'h03, rsp, cc);
        chk("write_ch7", cc, 16'hC087);
        frame(8'h01, 8'h07, 8'h00, rsp, cc);
        chk("read_ch7", 16'(rsp), 16'h0003);
        frame(8'h02, 8'h07, 8'h00, rsp, cc);
        chk("read_fb_ch7", 16'(rsp), 16'h0003);
        frame(8'h82, 8'h00, 8'h02, rsp, cc);
        chk("clear_inv2", 16'(invalid_req), 16'h0000);
        frame(8'h05, 8'h00, 8'h00, rsp, cc);
        chk("unknown_rsp", 16'(rsp), 16'h0000);
        chk("unknown_inv", 16'(invalid_req), 16'h0001);
        frame(8'h84, 8'h00, 8'h01, rsp, cc);
        chk("pg_set", 16'(pg_shutdown_out), 16'h0001);
        frame(8'h82, 8'h00, 8'h01, rsp, cc);
        chk("reset_req_cmd", cc, 16'h0000);
        chk("reset_req_keeps_inv", 16'(invalid_req), 16'h0001);
        frame(8'h04, 8'h00, 8'h00, rsp, cc);
        chk("read_sd", 16'(rsp), 16'h0002);
        frame(8'h81, 8'h02, 8'h03, rsp, cc);
        chk("write_ch2", cc, 16'h0030);
        spi.frame_start = 1'b1;
        @(negedge clk);
        spi.frame_start = 1'b0;
        word(8'h81);
        word(8'h05);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cmd", contactor_cmd, 16'h0000);
        chk("midrst_pg", 16'(pg_shutdown_out), 16'h0000);
        chk("midrst_inv", 16'(invalid_req), 16'h0000);
        word(8'h03);
        spi.frame_end = 1'b1;
        @(negedge clk);
        spi.frame_end = 1'b0;
        chk("midrst_no_commit", contactor_cmd, 16'h0000);
        chk("midrst_no_flag", 16'(invalid_req), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_contactor_ctrl.md
# spi_contactor_ctrl

Parametrised SPI command engine for the safety board. It sits between the SPI byte/word shifter and the contactor drivers. It parses framed SPI commands (cmd, index, data) and maintains N contactor command registers. Per-channel feedback is synchronised and watched for mismatch timeout. Shutdown and PG-shutdown latches are driven, and sticky error flags are exposed for read-back.

## Interface
- WORD_LEN, 8, SPI word width in bits (≥8); replaces the fixed global word-length define
- NUM_CH, 8, number of contactor channels (1..255)
- TIMEOUT_CYCLES, 1000, cycles of command/feedback mismatch before a channel timeout (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at chip-select assertion
- frame_end  in  1  one-cycle pulse at chip-select deassertion
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received word
- rx_data  in  WORD_LEN  received word
- tx_data  out  WORD_LEN  response word for the shifter
- contactor_cmd  out  NUM_CH×2  per channel {plus, minus} drive
- feedback_in  in  NUM_CH×2  asynchronous per channel {plus, minus} feedback
- shutdown_out  out  1  global shutdown
- pg_shutdown_out  out  1  direct PG shutdown
- timeout_err  out  1  sticky; OR of per-channel timeout flags
- invalid_req  out  1  sticky; bad command, index or frame

## Operation
- Frame format: word0 = command, word1 = channel index, word2 = write data, or a dummy word during a read response. Extra words before frame_end are ignored.
- FSM states:
  - IDLE → CMD on frame_start.
  - CMD → IDX on rx_valid; the command is latched.
  - IDX → DATA on rx_valid; the index is latched and the response is loaded.
  - DATA → DONE on rx_valid; a write commits here.
  - DONE → IDLE on frame_end.
  - frame_end in CMD, IDX or DATA: go to IDLE, commit nothing, set invalid_req.
  - frame_start in any state restarts at CMD.
- Command decode uses rx_data[7:0]. Any nonzero bit above bit 7 sets invalid_req.
- Unknown command codes set invalid_req. Reads respond with 0; writes are discarded.
- For CONTACTOR and FEEDBACK commands, index ≥ NUM_CH sets invalid_req. Reads respond with 0; writes are discarded.
- Read commands:
  - READ_CONTACTOR (0x01) → {0…, contactor_cmd[idx]}
  - READ_FEEDBACK (0x02) → {0…, synchronised feedback[idx]}
  - READ_STATUS (0x03) → bit WORD_LEN-1 = timeout_err, bit WORD_LEN-2 = invalid_req, rest 0
  - READ_SHUTDOWN (0x04) → {0…, pg_shutdown_out, shutdown_out}
- Write commands:
  - WRITE_CONTACTOR (0x81): cmd register[idx] ← data[1:0].
  - WRITE_CONTROL (0x82): data bit0 = reset_req, clearing all cmd registers and the shutdown latch. data bit1 = clear_errors, clearing all sticky flags and timeout counters. The index word is ignored.
  - WRITE_SHUTDOWN (0x83): shutdown latch ← data[0].
  - WRITE_PG_SHUTDOWN (0x84): pg_shutdown_out ← data[0].
- contactor_cmd = cmd register when shutdown_out = 0, else all zeros.
- Feedback path: two-flop synchroniser per bit.
- Timeout counter per channel:
  - Counts while synced feedback ≠ contactor_cmd.
  - Clears on a match or on any change of that channel's contactor_cmd.
  - Saturates at TIMEOUT_CYCLES and then sets the channel's sticky flag.
- Any timeout flag set also sets the shutdown latch.
- Simultaneous error set and clear_errors in the same cycle: set wins.

## Timing
- Reset values: tx_data = 0, contactor_cmd = 0, shutdown_out = 0, pg_shutdown_out = 0, timeout_err = 0, invalid_req = 0, FSM = IDLE, counters = 0, synchronisers = 0.
- tx_data is registered and valid one cycle after the index word's rx_valid. It holds until the next frame_start, which sets it to 0.
- Write effects appear on outputs one cycle after the data word's rx_valid.
- Feedback-to-counter latency is 2 cycles.
- timeout_err asserts TIMEOUT_CYCLES + 1 cycles after the first mismatched synced sample. shutdown_out asserts in the same cycle.
- rx_valid is accepted every cycle; back-to-back words need no gap.
- rst mid-frame aborts the frame. All state returns to reset values and no flag is set.

## Structure
- spi_pkg holds:
  - spi_cmd_t
  - status and control bit-position constants
  - contactor_data_t
  - the WORD_LEN default as a package parameter, replacing the global define
  - the FSM state enum
- Sub-module fb_timeout_monitor: one per channel, instantiated in a generate loop. It contains the synchroniser, mismatch counter and sticky flag, with a clear input.

## Test plan
- Frame 0x81, 0x03, 0x02 (NUM_CH=8) → contactor_cmd[3] = 2'b10 one cycle after the third rx_valid. Then frame 0x01, 0x03, dummy → tx_data = 0x02.
- Frame 0x81, 0x09, 0x03 with NUM_CH=8 → no register changes. A later READ_STATUS returns 0x40.
- Channel 0 set to 2'b11 with feedback held at 2'b00 and TIMEOUT_CYCLES=16 → timeout_err and shutdown_out rise at cycle 19 after the command, and all contactor_cmd = 0.
- After the timeout, WRITE_CONTROL data 0x02 → timeout_err = 0 and invalid_req = 0. Then WRITE_SHUTDOWN data 0x00 → channel outputs are restored.
- frame_end after two words of a 0x81 frame → no write occurs and invalid_req = 1. A new frame then works normally.
- rst asserted between the index word and the data word of a write → all outputs at reset values and no write is committed.
